// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed common-anode 7-segment driver.
// Slot blanking, per-digit DP/enable, leading-zero blanking, hex/dec glyphs.
module seven_seg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter bit HEX_MODE     = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    LzBlank,
  input  logic                    Load,
  output logic                    CA,
  output logic                    CB,
  output logic                    CC,
  output logic                    CD,
  output logic                    CE,
  output logic                    CF,
  output logic                    CG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } phase_t;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    lz_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q;

  logic                    in_blank;
  phase_t                  phase;
  logic [NUM_DIGITS-1:0]   upz;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [3:0]              cur_nib;
  logic                    cur_en;
  logic                    cur_dp;
  logic                    cur_upz;
  logic                    glyph_ok;
  logic                    sup;
  logic [6:0]              glyph;
  logic                    z;

  assign {CA, CB, CC, CD, CE, CF, CG} = seg_q;
  assign DP = dp_q;
  assign AN = an_q;

  if (BLANK_CYCLES == 0) begin : g_noblank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (cnt < CW'(BLANK_CYCLES));
  end

  // Select the current digit's data and decide whether it is suppressed.
  always_comb begin
    phase   = in_blank ? BLANK : ON;
    upz     = '0;
    an_sel  = '1;
    cur_nib = 4'h0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    cur_upz = 1'b0;
    z       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z      = z & (sh_val[4*i +: 4] == 4'h0);
      upz[i] = z;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = sh_val[4*i +: 4];
        cur_en    = en_q[i];
        cur_dp    = sh_dp[i];
        cur_upz   = upz[i];
        an_sel[i] = 1'b0;
      end
    end
    glyph_ok = HEX_MODE || (cur_nib < 4'd10);
    sup = !cur_en || !glyph_ok ||
          (lz_q && (idx != '0) && cur_upz);
  end

  // Nibble to active-low CA..CG pattern.
  always_comb begin
    case (cur_nib)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b1100000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1000010;
      4'hE:    glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  end

  // Shadow capture and per-cycle sampling of enables.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sh_val <= '0;
      sh_dp  <= '0;
      en_q   <= '0;
      lz_q   <= 1'b0;
    end else begin
      if (Load) begin
        sh_val <= Value;
        sh_dp  <= DpIn;
      end
      en_q <= DigitEn;
      lz_q <= LzBlank;
    end
  end

  // Slot counter and digit index; cnt names the cycle of the next edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered pins for the phase of the cycle at this edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
    end else if (phase == BLANK || sup) begin
      an_q  <= '1;
      seg_q <= '1;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_sel;
      seg_q <= glyph;
      dp_q  <= ~cur_dp;
    end
  end

endmodule
